// File: rtl/wb_arbiter.sv
// wb_arbiter: buffered round-robin writeback into the register file.
// One holding slot per producer and one registered write per cycle.
module wb_arbiter #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int ADDR_W  = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_flush,
  input  logic [NUM_SRC-1:0]        i_src_valid,
  output logic [NUM_SRC-1:0]        o_src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] i_src_rd,
  input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
  output logic                      o_rd_wren,
  output logic [ADDR_W-1:0]         o_rd_addr,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic                      o_idle
);

  localparam int PTR_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] slot_valid_q, slot_valid_d;
  logic [ADDR_W-1:0]  slot_rd_q   [NUM_SRC];
  logic [ADDR_W-1:0]  slot_rd_d   [NUM_SRC];
  logic [DATA_W-1:0]  slot_data_q [NUM_SRC];
  logic [DATA_W-1:0]  slot_data_d [NUM_SRC];
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               rd_wren_q, rd_wren_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;

  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] capture;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W:0]     scan_sum;
  logic [PTR_W-1:0]   scan_idx;

  // Round-robin search: first valid slot at or above rr_ptr, wrapping.
  always_comb begin
    grant    = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (scan_sum >= (PTR_W+1)'(NUM_SRC))
        scan_sum = scan_sum - (PTR_W+1)'(NUM_SRC);
      scan_idx = scan_sum[PTR_W-1:0];
      if (!gnt_any && slot_valid_q[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (gnt_any)
      grant[gnt_idx] = 1'b1;
  end

  // Ready comes from state only, so producers never see a loop.
  assign o_src_ready = ~slot_valid_q | grant;
  assign capture     = i_src_valid & o_src_ready & {NUM_SRC{~i_flush}};
  assign o_idle      = ~|slot_valid_q;

  // Slot update: drain on grant, refill on capture, flush drops all.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_rd_d    = slot_rd_q;
    slot_data_d  = slot_data_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant[k])
        slot_valid_d[k] = 1'b0;
      if (capture[k]) begin
        slot_valid_d[k] = 1'b1;
        slot_rd_d[k]    = i_src_rd[k*ADDR_W +: ADDR_W];
        slot_data_d[k]  = i_src_data[k*DATA_W +: DATA_W];
      end
    end
    if (i_flush)
      slot_valid_d = '0;
  end

  // Pointer advance past the winner; x0 results consume a slot silently.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any)
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_SRC-1)) ? '0
                                                 : gnt_idx + PTR_W'(1);
    rd_wren_d = gnt_any && (slot_rd_q[gnt_idx] != '0);
    rd_addr_d = rd_wren_d ? slot_rd_q[gnt_idx]   : '0;
    rd_data_d = rd_wren_d ? slot_data_q[gnt_idx] : '0;
  end

  // State registers; reset discards slots and any pending write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_valid_q <= '0;
      rr_ptr_q     <= '0;
      rd_wren_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      for (int k = 0; k < NUM_SRC; k++) begin
        slot_rd_q[k]   <= '0;
        slot_data_q[k] <= '0;
      end
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_rd_q    <= slot_rd_d;
      slot_data_q  <= slot_data_d;
      rr_ptr_q     <= rr_ptr_d;
      rd_wren_q    <= rd_wren_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign o_rd_wren = rd_wren_q;
  assign o_rd_addr = rd_addr_q;
  assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of wb_arbiter writeback ordering.
// Vectors and expected writes are hand-derived per scenario.
module tb_wb_arbiter;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic [NS-1:0]  src_valid = '0;
  logic [NS-1:0]  ready;
  logic [NS*AW-1:0] src_rd = '0;
  logic [NS*DW-1:0] src_data = '0;
  logic           wren;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  data;
  logic           idle;

  int checks = 0;
  int errors = 0;
  int cnt;
  int ch;
  int seq_in  [NS];
  int seq_out [NS];
  int win     [NS];

  wb_arbiter #(.DATA_W(DW), .NUM_SRC(NS), .ADDR_W(AW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_src_valid (src_valid),
    .o_src_ready (ready),
    .i_src_rd    (src_rd),
    .i_src_data  (src_data),
    .o_rd_wren   (wren),
    .o_rd_addr   (addr),
    .o_rd_data   (data),
    .o_idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic v,
                         input logic [AW-1:0] rd, input logic [DW-1:0] d);
    src_valid[k]        = v;
    src_rd[k*AW +: AW]  = rd;
    src_data[k*DW +: DW] = d;
  endtask

  // All four channels load in one edge; writes follow from channel first.
  task automatic rr_burst(input string tag, input int first);
    for (int k = 0; k < NS; k++)
      set_src(k, 1'b1, AW'(k+1), DW'(k));
    step();
    src_valid = '0;
    for (int j = 0; j < NS; j++) begin
      step();
      check({tag, "_wren"}, wren, 1);
      check({tag, "_addr"}, addr, 64'((first + j) % NS + 1));
      check({tag, "_data"}, data, 64'((first + j) % NS));
    end
    step();
    check({tag, "_end"}, wren, 0);
    check({tag, "_idle"}, idle, 1);
  endtask

  initial begin
    // reset state
    step();
    step();
    check("rst_wren", wren, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    check("rst_ready", ready, 4'hF);
    check("rst_idle", idle, 1);
    #2 rst = 1'b0;
    step();

    // single result on ch1
    set_src(1, 1'b1, 5'd7, 32'hDEADBEEF);
    step();
    src_valid = '0;
    check("s1_ready", ready, 4'hF);
    check("s1_idle", idle, 0);
    check("s1_early", wren, 0);
    step();
    check("s1_wren", wren, 1);
    check("s1_addr", addr, 7);
    check("s1_data", data, 32'hDEADBEEF);
    check("s1_idle2", idle, 1);
    step();
    check("s1_once", wren, 0);

    // ch1 streams 8 back-to-back results
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        set_src(1, 1'b1, AW'(8 + i), DW'(100 + i));
        check("st_ready", ready[1], 1);
      end else begin
        src_valid = '0;
      end
      step();
      if (i >= 1 && i <= 8) begin
        check("st_wren", wren, 1);
        check("st_addr", addr, 64'(8 + i - 1));
        check("st_data", data, 64'(100 + i - 1));
      end else begin
        check("st_idle_wren", wren, 0);
      end
    end

    // reset mid-stream with three slots full (pointer sits at 2)
    set_src(0, 1'b1, 5'd20, 32'hA0);
    set_src(2, 1'b1, 5'd22, 32'hA2);
    set_src(3, 1'b1, 5'd23, 32'hA3);
    step();
    src_valid = '0;
    check("mr_idle", idle, 0);
    check("mr_ready", ready, 4'b0110);
    step();
    check("mr_wren", wren, 1);
    check("mr_addr", addr, 22);
    check("mr_data", data, 32'hA2);
    #2 rst = 1'b1;
    #1;
    check("mr_rst_wren", wren, 0);
    check("mr_rst_addr", addr, 0);
    check("mr_rst_data", data, 0);
    check("mr_rst_ready", ready, 4'hF);
    check("mr_rst_idle", idle, 1);
    #1 rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      step();
      if (wren) cnt++;
    end
    check("mr_no_write", cnt, 0);

    // round-robin ordering
    rr_burst("rr0", 0);
    rr_burst("rr1", 0);
    set_src(1, 1'b1, 5'd9, 32'h99);
    step();
    src_valid = '0;
    step();
    check("rr_mv_addr", addr, 9);
    step();
    rr_burst("rr2", 2);

    // x0 result consumed without a write, pointer moves to 1
    set_src(0, 1'b1, 5'd0, 32'h55);
    step();
    src_valid = '0;
    check("x0_idle", idle, 0);
    step();
    check("x0_wren", wren, 0);
    check("x0_addr", addr, 0);
    check("x0_data", data, 0);
    check("x0_freed", idle, 1);
    rr_burst("x0rr", 1);

    // all four valid for 12 cycles, pointer starts at 1
    for (int k = 0; k < NS; k++) begin
      seq_in[k]  = 0;
      seq_out[k] = 0;
      win[k]     = 0;
    end
    for (int s = 0; s < 17; s++) begin
      if (s < 12) begin
        for (int k = 0; k < NS; k++)
          set_src(k, 1'b1, AW'(k + 1), DW'(k * 256 + seq_in[k]));
        if (s == 0)
          check("bp_ready0", ready, 4'hF);
        else
          check("bp_ready", ready, 64'(1 << (s % 4)));
        for (int k = 0; k < NS; k++)
          if (ready[k]) seq_in[k]++;
      end else begin
        src_valid = '0;
      end
      step();
      if (wren) begin
        ch = int'(addr) - 1;
        if (ch < 0 || ch >= NS) begin
          check("bp_addr", addr, 1);
        end else begin
          check("bp_data", data, 64'(ch * 256 + seq_out[ch]));
          seq_out[ch]++;
          if (s >= 1 && s <= 12) win[ch]++;
        end
      end
    end
    for (int k = 0; k < NS; k++) begin
      check("bp_fair", win[k], 3);
      check("bp_total", seq_out[k], (k == 0) ? 3 : 4);
    end
    check("bp_idle", idle, 1);

    // flush with slot 0 granted and slot 2 waiting
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    step();
    set_src(0, 1'b1, 5'd10, 32'hAA);
    set_src(2, 1'b1, 5'd12, 32'hCC);
    step();
    src_valid = '0;
    check("fl_ready", ready, 4'b1011);
    check("fl_busy", idle, 0);
    flush = 1'b1;
    set_src(3, 1'b1, 5'd13, 32'hDD);
    step();
    flush = 1'b0;
    src_valid = '0;
    check("fl_wren", wren, 1);
    check("fl_addr", addr, 10);
    check("fl_data", data, 32'hAA);
    check("fl_idle", idle, 1);
    cnt = 0;
    repeat (3) begin
      step();
      if (wren) cnt++;
    end
    check("fl_no_more", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
